// File: rtl/nonce_uart_tx_pkg.sv
// Shared definitions for the nonce UART transmit path.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT - baud divider for 100 MHz / 115200
//   DATA_BITS, STOP_BITS - 8N1 frame shape
//   tx_state_e           - byte transmitter states (IDLE, START, DATA, STOP)
//   word_state_e         - word sequencer states (IDLE, SEND)
//   cnt_width()          - counter width helper that never returns zero
package nonce_uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic {
        WORD_IDLE = 1'b0,
        WORD_SEND = 1'b1
    } word_state_e;

    // Width of a counter running 0..range-1; a range of 1 still gets one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   byte_in    - byte to send, sampled when byte_valid && byte_ready
//   byte_valid - byte_in is valid
//   byte_ready - transmitter can take a byte: in IDLE, and also in the last
//                cycle of the stop bit so bytes can be chained with no gap
//   txd        - registered serial output, idles high
module uart_tx_byte
    import nonce_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 txd
);

    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;

    logic baud_wrap;
    logic stop_end;
    logic accept;

    // A bit ends on the cycle the baud counter wraps.
    assign baud_wrap  = (baud_cnt_q == BAUD_LAST);
    assign stop_end   = (state_q == ST_STOP) && baud_wrap && (bit_cnt_q == STOP_LAST);
    assign byte_ready = (state_q == ST_IDLE) || stop_end;
    assign accept     = byte_valid && byte_ready;
    assign txd        = txd_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = 1'b1;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    shift_d    = byte_in;
                    baud_cnt_d = '0;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    if (bit_cnt_q != STOP_LAST) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else if (accept) begin
                        // Chain straight into the next start bit.
                        state_d = ST_START;
                        shift_d = byte_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // txd follows the state being entered so the line is registered.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/nonce_uart_tx.sv
// Sends a result word (normally a found nonce) as WORD_BYTES back-to-back
// 8N1 UART frames, most significant byte first.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   word_in    - word to send, sampled only when word_valid && word_ready
//   word_valid - word_in is valid
//   word_ready - high only while idle
//   txd        - UART serial output, idles high
//   busy       - high from acceptance until the last stop bit completes
//   done       - one-cycle pulse in the first idle cycle after a word
module nonce_uart_tx
    import nonce_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_BITS*WORD_BYTES-1:0] word_in,
    input  logic                            word_valid,
    output logic                            word_ready,
    output logic                            txd,
    output logic                            busy,
    output logic                            done
);

    localparam int WORD_W = DATA_BITS * WORD_BYTES;
    localparam int CNT_W  = cnt_width(WORD_BYTES);

    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(WORD_BYTES - 1);

    word_state_e          state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                 done_q, done_d;

    logic                 byte_valid;
    logic                 byte_ready;
    logic [DATA_BITS-1:0] byte_data;
    logic                 more_bytes;

    // byte_cnt_q indexes the byte currently on the line.
    assign more_bytes = (byte_cnt_q != BYTE_LAST);
    assign busy       = (state_q == WORD_SEND);
    assign done       = done_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clock     (clock),
        .reset     (reset),
        .byte_in   (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .txd       (txd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= WORD_IDLE;
            word_q     <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        word_ready = (state_q == WORD_IDLE);
        byte_valid = 1'b0;
        byte_data  = word_q[WORD_W-1 -: DATA_BITS];

        case (state_q)
            WORD_IDLE: begin
                // The first byte goes straight from word_in to the byte
                // transmitter so its start bit begins the next cycle.
                byte_valid = word_valid;
                byte_data  = word_in[WORD_W-1 -: DATA_BITS];
                if (word_valid && byte_ready) begin
                    state_d    = WORD_SEND;
                    word_d     = word_in << DATA_BITS;
                    byte_cnt_d = '0;
                end
            end
            WORD_SEND: begin
                // byte_ready here is the last stop-bit cycle of the current byte.
                byte_valid = more_bytes;
                if (byte_ready) begin
                    if (more_bytes) begin
                        word_d     = word_q << DATA_BITS;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end else begin
                        state_d    = WORD_IDLE;
                        byte_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: state_d = WORD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nonce_uart_tx.sv
module tb_nonce_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] word_in = '0;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_a, txd_a, busy_a, done_a;
    logic        ready_b, txd_b, busy_b, done_b;

    int passed = 0;
    int total  = 0;

    logic cap_txd [0:639];
    int   bad_busy, bad_done, bad_ready;
    logic end_done, end_busy, end_ready;

    always #5 clk = ~clk;

    nonce_uart_tx #(.CLKS_PER_BIT(4), .WORD_BYTES(4)) dut_a (
        .clock(clk), .reset(rst_n), .word_in(word_in), .word_valid(valid_a),
        .word_ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    nonce_uart_tx #(.CLKS_PER_BIT(2), .WORD_BYTES(4)) dut_b (
        .clock(clk), .reset(rst_n), .word_in(word_in), .word_valid(valid_b),
        .word_ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic get_txd(input int which);   return which != 0 ? txd_b   : txd_a;   endfunction
    function automatic logic get_busy(input int which);  return which != 0 ? busy_b  : busy_a;  endfunction
    function automatic logic get_done(input int which);  return which != 0 ? done_b  : done_a;  endfunction
    function automatic logic get_ready(input int which); return which != 0 ? ready_b : ready_a; endfunction
    function automatic logic get_valid(input int which); return which != 0 ? valid_b : valid_a; endfunction

    // Reference line level k cycles after the start bit begins: frames of
    // 10 bits (start, 8 data LSB first, stop), MSB byte first.
    function automatic logic model_txd(input logic [31:0] w, input int cpb, input int k);
        int pos, frame, b;
        logic [7:0] by;
        pos   = k / cpb;
        frame = pos / 10;
        b     = pos % 10;
        by    = 8'(w >> (8 * (3 - frame)));
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    function automatic logic [7:0] expect_byte(input logic [31:0] w, input int f);
        return 8'(w >> (8 * (3 - f)));
    endfunction

    // UART sampler: reads each data bit at its centre.
    function automatic logic [7:0] decode_byte(input int base, input int cpb, input int frame);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) v[b] = cap_txd[base + (frame * 10 + 1 + b) * cpb + cpb / 2];
        return v;
    endfunction

    function automatic int wave_errors(input int base, input logic [31:0] w, input int cpb);
        int n;
        n = 0;
        for (int k = 0; k < 40 * cpb; k++) if (cap_txd[base + k] !== model_txd(w, cpb, k)) n++;
        return n;
    endfunction

    // Waits for a handshake, then returns 1 ns after the accepting edge.
    task automatic wait_accept(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (get_ready(which) && get_valid(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Records n cycles of txd plus the following (done) cycle.
    task automatic capture(input int which, input int base, input int n);
        bad_busy = 0; bad_done = 0; bad_ready = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_txd[base + k] = get_txd(which);
            if (get_busy(which) !== 1'b1) bad_busy++;
            if (get_done(which) !== 1'b0) bad_done++;
            if (get_ready(which) !== 1'b0) bad_ready++;
        end
        @(negedge clk);
        end_done  = get_done(which);
        end_busy  = get_busy(which);
        end_ready = get_ready(which);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        total++; if ({txd_a, ready_a, busy_a, done_a} !== 4'b1100) $display("FAIL reset_a: got %b want 1100", {txd_a, ready_a, busy_a, done_a}); else passed++;
        total++; if ({txd_b, ready_b, busy_b, done_b} !== 4'b1100) $display("FAIL reset_b: got %b want 1100", {txd_b, ready_b, busy_b, done_b}); else passed++;
        repeat (3) @(negedge clk);
        total++; if ({txd_a, ready_a, busy_a, done_a} !== 4'b1100) $display("FAIL reset_hold_a: got %b want 1100", {txd_a, ready_a, busy_a, done_a}); else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({txd_a, ready_a, busy_a} !== 3'b110) $display("FAIL idle_after_reset: got %b want 110", {txd_a, ready_a, busy_a}); else passed++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] w;
        w = 32'h12345678;
        word_in = w; valid_a = 1'b1;
        wait_accept(0, ok);
        valid_a = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL basic_accept: got %b want 1", ok); else passed++;
        capture(0, 0, 160);
        total++; if (cap_txd[0] !== 1'b0) $display("FAIL basic_start_t1: got %b want 0", cap_txd[0]); else passed++;
        total++; if (wave_errors(0, w, 4) != 0) $display("FAIL basic_wave: got %0d bad cycles want 0", wave_errors(0, w, 4)); else passed++;
        for (int f = 0; f < 4; f++) begin
            total++; if (decode_byte(0, 4, f) !== expect_byte(w, f)) $display("FAIL basic_byte%0d: got %h want %h", f, decode_byte(0, 4, f), expect_byte(w, f)); else passed++;
        end
        total++; if (bad_busy != 0) $display("FAIL basic_busy: got %0d low cycles want 0", bad_busy); else passed++;
        total++; if (bad_done != 0 || bad_ready != 0) $display("FAIL basic_early_done_ready: got %0d/%0d want 0/0", bad_done, bad_ready); else passed++;
        total++; if ({end_done, end_busy, end_ready} !== 3'b101) $display("FAIL basic_done_t161: got %b want 101", {end_done, end_busy, end_ready}); else passed++;
        @(negedge clk);
        total++; if (done_a !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done_a); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] w0, w1;
        w0 = 32'hDEADBEEF; w1 = 32'h00000001;
        word_in = w0; valid_a = 1'b1;
        wait_accept(0, ok);
        total++; if (ok !== 1'b1) $display("FAIL b2b_accept: got %b want 1", ok); else passed++;
        word_in = w1;
        capture(0, 0, 160);
        total++; if ({end_done, end_ready} !== 2'b11) $display("FAIL b2b_done_ready: got %b want 11", {end_done, end_ready}); else passed++;
        @(posedge clk);
        #1 valid_a = 1'b0;
        capture(0, 160, 160);
        total++; if ({cap_txd[159], cap_txd[160]} !== 2'b10) $display("FAIL b2b_gap: got %b want 10", {cap_txd[159], cap_txd[160]}); else passed++;
        total++; if (wave_errors(0, w0, 4) + wave_errors(160, w1, 4) != 0) $display("FAIL b2b_wave: got %0d bad cycles want 0", wave_errors(0, w0, 4) + wave_errors(160, w1, 4)); else passed++;
        for (int f = 0; f < 8; f++) begin
            total++;
            if (decode_byte(f < 4 ? 0 : 160, 4, f % 4) !== expect_byte(f < 4 ? w0 : w1, f % 4))
                $display("FAIL b2b_byte%0d: got %h want %h", f, decode_byte(f < 4 ? 0 : 160, 4, f % 4), expect_byte(f < 4 ? w0 : w1, f % 4));
            else passed++;
        end
        total++; if ({end_done, bad_busy} !== {1'b1, 32'd0}) $display("FAIL b2b_second_done: got done=%b busy_low=%0d want 1/0", end_done, bad_busy); else passed++;
    endtask

    task automatic test_stability();
        bit ok;
        word_in = 32'hA5A5A5A5; valid_a = 1'b1;
        wait_accept(0, ok);
        valid_a = 1'b0;
        word_in = 32'hFFFFFFFF;
        total++; if (ok !== 1'b1) $display("FAIL stable_accept: got %b want 1", ok); else passed++;
        capture(0, 0, 160);
        for (int f = 0; f < 4; f++) begin
            total++; if (decode_byte(0, 4, f) !== 8'hA5) $display("FAIL stable_byte%0d: got %h want a5", f, decode_byte(0, 4, f)); else passed++;
        end
        total++; if (wave_errors(0, 32'hA5A5A5A5, 4) != 0) $display("FAIL stable_wave: got %0d bad cycles want 0", wave_errors(0, 32'hA5A5A5A5, 4)); else passed++;
    endtask

    task automatic test_busy_reject();
        bit ok;
        logic [31:0] w;
        logic ready_seen;
        int after_bad;
        w = $urandom;
        word_in = w; valid_a = 1'b1;
        wait_accept(0, ok);
        valid_a = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL reject_accept: got %b want 1", ok); else passed++;
        ready_seen = 1'b1;
        fork
            capture(0, 0, 160);
            begin
                repeat (50) @(negedge clk);
                #1 word_in = 32'h11111111; valid_a = 1'b1;
                @(negedge clk);
                ready_seen = ready_a;
                @(posedge clk);
                #1 valid_a = 1'b0;
            end
        join
        total++; if (ready_seen !== 1'b0) $display("FAIL reject_ready: got %b want 0", ready_seen); else passed++;
        total++; if (wave_errors(0, w, 4) != 0) $display("FAIL reject_wave: got %0d bad cycles want 0", wave_errors(0, w, 4)); else passed++;
        total++; if ({end_done, end_ready} !== 2'b11) $display("FAIL reject_done: got %b want 11", {end_done, end_ready}); else passed++;
        after_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || txd_a !== 1'b1) after_bad++;
        end
        total++; if (after_bad != 0) $display("FAIL reject_no_second_word: got %0d active cycles want 0", after_bad); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [31:0] w;
        int done_seen;
        w = 32'h12345678;
        word_in = w; valid_a = 1'b1;
        wait_accept(0, ok);
        valid_a = 1'b0;
        // Data bit 3 of the third frame covers offsets 96..99.
        repeat (98) @(negedge clk);
        total++; if (txd_a !== model_txd(w, 4, 97)) $display("FAIL midframe_pre: got %b want %b", txd_a, model_txd(w, 4, 97)); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if ({txd_a, ready_a, busy_a, done_a} !== 4'b1100) $display("FAIL midframe_async: got %b want 1100", {txd_a, ready_a, busy_a, done_a}); else passed++;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done_a !== 1'b0 || txd_a !== 1'b1 || busy_a !== 1'b0) done_seen++;
        end
        total++; if (done_seen != 0) $display("FAIL midframe_quiet: got %0d active cycles want 0", done_seen); else passed++;
        w = 32'hCAFEF00D;
        word_in = w; valid_a = 1'b1;
        wait_accept(0, ok);
        valid_a = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL midframe_reaccept: got %b want 1", ok); else passed++;
        capture(0, 0, 160);
        total++; if (wave_errors(0, w, 4) != 0) $display("FAIL midframe_wave: got %0d bad cycles want 0", wave_errors(0, w, 4)); else passed++;
        for (int f = 0; f < 4; f++) begin
            total++; if (decode_byte(0, 4, f) !== expect_byte(w, f)) $display("FAIL midframe_byte%0d: got %h want %h", f, decode_byte(0, 4, f), expect_byte(w, f)); else passed++;
        end
        total++; if (end_done !== 1'b1) $display("FAIL midframe_done: got %b want 1", end_done); else passed++;
    endtask

    task automatic test_edge_params();
        bit ok;
        logic [31:0] w;
        w = 32'h80000001;
        word_in = w; valid_b = 1'b1;
        wait_accept(1, ok);
        valid_b = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL edge_accept: got %b want 1", ok); else passed++;
        capture(1, 0, 80);
        total++; if (cap_txd[0] !== 1'b0) $display("FAIL edge_start: got %b want 0", cap_txd[0]); else passed++;
        total++; if (wave_errors(0, w, 2) != 0) $display("FAIL edge_wave: got %0d bad cycles want 0", wave_errors(0, w, 2)); else passed++;
        for (int f = 0; f < 4; f++) begin
            total++; if (decode_byte(0, 2, f) !== expect_byte(w, f)) $display("FAIL edge_byte%0d: got %h want %h", f, decode_byte(0, 2, f), expect_byte(w, f)); else passed++;
        end
        total++; if (bad_busy != 0) $display("FAIL edge_busy: got %0d low cycles want 0", bad_busy); else passed++;
        total++; if ({end_done, end_busy, end_ready} !== 3'b101) $display("FAIL edge_done_t81: got %b want 101", {end_done, end_busy, end_ready}); else passed++;
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] w;
        int which, cpb;
        for (int i = 0; i < 6; i++) begin
            which = i % 2;
            cpb   = (which != 0) ? 2 : 4;
            w     = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            word_in = w;
            if (which != 0) valid_b = 1'b1; else valid_a = 1'b1;
            wait_accept(which, ok);
            valid_a = 1'b0; valid_b = 1'b0;
            total++; if (ok !== 1'b1) $display("FAIL rand%0d_accept: got %b want 1", i, ok); else passed++;
            capture(which, 0, 40 * cpb);
            total++; if (wave_errors(0, w, cpb) != 0) $display("FAIL rand%0d_wave: word %h got %0d bad cycles want 0", i, w, wave_errors(0, w, cpb)); else passed++;
            total++; if ({decode_byte(0, cpb, 0), decode_byte(0, cpb, 1), decode_byte(0, cpb, 2), decode_byte(0, cpb, 3)} !== w)
                $display("FAIL rand%0d_bytes: got %h want %h", i, {decode_byte(0, cpb, 0), decode_byte(0, cpb, 1), decode_byte(0, cpb, 2), decode_byte(0, cpb, 3)}, w);
            else passed++;
            total++; if ({end_done, end_busy, bad_busy} !== {2'b10, 32'd0}) $display("FAIL rand%0d_timing: got done=%b busy=%b busy_low=%0d want 1/0/0", i, end_done, end_busy, bad_busy); else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stability();
        test_busy_reject();
        test_reset_midframe();
        test_edge_params();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
